// File: rtl/crono_control_if.sv
// Handshake/bus bundle between the button front end, crono_control and the
// display chain; the master drives the button/preset side.
interface crono_control_if;
    logic       btn_start;
    logic       btn_clear;
    logic       load_en;
    logic [5:0] load_min;
    logic [5:0] load_sec;
    logic [5:0] Segundos;
    logic [5:0] Minutos;
    logic       scan_tick;
    logic       running;
    logic       alarm;

    modport master (
        output btn_start, btn_clear, load_en, load_min, load_sec,
        input  Segundos, Minutos, scan_tick, running, alarm
    );

    modport slave (
        input  btn_start, btn_clear, load_en, load_min, load_sec,
        output Segundos, Minutos, scan_tick, running, alarm
    );
endinterface

// File: rtl/crono_control.sv
// Run/pause/clear sequencer, 1 Hz prescaler and display scan strobe.
// Define CRONO_COUNTDOWN_EN to build a preset countdown timer instead of a stopwatch.
module crono_control #(
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 50000
) (
    input logic            clk,
    input logic            rst,
    crono_control_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [PW-1:0] r_pre;
    logic [SW-1:0] r_scan_cnt;
    logic          r_scan_tick;
    logic [5:0]    r_sec;
    logic [5:0]    r_min;
    logic          r_running;
    logic          r_alarm;

    logic          w_sec_tick;
    logic          w_adv;
    logic          w_term;
    logic          w_can_start;
    logic [5:0]    w_sec_n;
    logic [5:0]    w_min_n;

    assign w_sec_tick = (r_state == S_RUN) && (r_pre == PRE_MAX);

`ifdef CRONO_COUNTDOWN_EN
    logic          w_load;
    logic [5:0]    w_load_min;
    logic [5:0]    w_load_sec;

    assign w_load     = bus.load_en && (r_state == S_IDLE) && !bus.btn_clear;
    assign w_load_min = (bus.load_min > 6'd59) ? 6'd59 : bus.load_min;
    assign w_load_sec = (bus.load_sec > 6'd59) ? 6'd59 : bus.load_sec;

    always_comb begin
        w_sec_n = r_sec - 6'd1;
        w_min_n = r_min;
        if (r_sec == 6'd0) begin
            w_sec_n = 6'd59;
            w_min_n = r_min - 6'd1;
        end
    end

    assign w_term      = (w_sec_n == 6'd0) && (w_min_n == 6'd0);
    assign w_can_start = (r_sec != 6'd0) || (r_min != 6'd0);
`else
    logic w_unused_load;
    assign w_unused_load = ^{bus.load_en, bus.load_min, bus.load_sec};

    always_comb begin
        w_sec_n = r_sec + 6'd1;
        w_min_n = r_min;
        if (r_sec == 6'd59) begin
            w_sec_n = 6'd0;
            w_min_n = r_min + 6'd1;
        end
    end

    assign w_term      = (w_sec_n == 6'd59) && (w_min_n == 6'd59);
    assign w_can_start = 1'b1;
`endif

    // A start press in RUN wins over a coincident second tick (tick dropped).
    always_comb begin
        w_next = r_state;
        w_adv  = 1'b0;
        if (bus.btn_clear) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.btn_start && w_can_start)
                        w_next = S_RUN;
                end
                S_RUN: begin
                    if (bus.btn_start) begin
                        w_next = S_PAUSE;
                    end else if (w_sec_tick) begin
                        w_adv = 1'b1;
                        if (w_term)
                            w_next = S_DONE;
                    end
                end
                S_PAUSE: begin
                    if (bus.btn_start)
                        w_next = S_RUN;
                end
                S_DONE: w_next = S_DONE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
            r_alarm   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_running <= (w_next == S_RUN);
            r_alarm   <= (w_next == S_DONE);
        end
    end

    // Prescaler only advances while staying in RUN; entering/leaving PAUSE holds it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= '0;
        end else if (w_next == S_IDLE || w_next == S_DONE) begin
            r_pre <= '0;
        end else if (r_state == S_RUN && w_next == S_RUN) begin
            r_pre <= w_sec_tick ? '0 : r_pre + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.btn_clear) begin
            r_sec <= 6'd0;
            r_min <= 6'd0;
        end else if (w_adv) begin
            r_sec <= w_sec_n;
            r_min <= w_min_n;
`ifdef CRONO_COUNTDOWN_EN
        end else if (w_load) begin
            r_sec <= w_load_sec;
            r_min <= w_load_min;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt  <= '0;
            r_scan_tick <= 1'b0;
        end else begin
            r_scan_cnt  <= (r_scan_cnt == SCAN_MAX) ? '0 : r_scan_cnt + 1'b1;
            r_scan_tick <= (r_scan_cnt == SCAN_MAX);
        end
    end

    assign bus.Segundos  = r_sec;
    assign bus.Minutos   = r_min;
    assign bus.scan_tick = r_scan_tick;
    assign bus.running   = r_running;
    assign bus.alarm     = r_alarm;
endmodule

// File: tb/tb_crono_control.sv
// Directed bench for crono_control with TICK_DIV=4, SCAN_DIV=3.
module tb_crono_control;
    localparam int TD = 4;
    localparam int SD = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    crono_control_if bus();

    crono_control #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic start;
        logic clear;
        int   reps;
        int   sec;
        int   min;
        logic run;
        logic alm;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic chk_out(input string nm, input int sec, input int min,
                           input logic run, input logic alm);
        chk({nm, ".sec"}, 32'(bus.Segundos), sec);
        chk({nm, ".min"}, 32'(bus.Minutos), min);
        chk({nm, ".run"}, 32'(bus.running), 32'(run));
        chk({nm, ".alarm"}, 32'(bus.alarm), 32'(alm));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic c, input logic l,
                         input logic [5:0] lm, input logic [5:0] ls);
        bus.btn_start = s;
        bus.btn_clear = c;
        bus.load_en   = l;
        bus.load_min  = lm;
        bus.load_sec  = ls;
    endtask

    initial begin
        // start, clear, reps, sec, min, running, alarm (after each rep)
        tbl[0] = '{1'b1, 1'b0, 1,  0, 0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 3,  0, 0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 4,  1, 0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 2,  2, 0, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1,  2, 0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 10, 2, 0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 1,  2, 0, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1,  2, 0, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1,  2, 0, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 1,  3, 0, 1'b1, 1'b0};

        drive(0, 0, 0, 6'd0, 6'd0);
        rst = 1'b1;
        tick();
        chk_out("rst1", 0, 0, 1'b0, 1'b0);
        chk("rst1.scan", 32'(bus.scan_tick), 0);
        tick();
        chk_out("rst2", 0, 0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk($sformatf("scan%0d", c), 32'(bus.scan_tick), (c % 3 == 0) ? 1 : 0);
        end
        chk_out("idle12", 0, 0, 1'b0, 1'b0);

`ifdef CRONO_COUNTDOWN_EN
        drive(0, 0, 1, 6'd0, 6'd63);
        tick();
        chk_out("load63", 59, 0, 1'b0, 1'b0);
        drive(0, 0, 1, 6'd70, 6'd5);
        tick();
        chk_out("load70", 5, 59, 1'b0, 1'b0);
        drive(0, 0, 1, 6'd0, 6'd63);
        tick();
        chk_out("reload", 59, 0, 1'b0, 1'b0);
        drive(1, 0, 0, 6'd0, 6'd0);
        tick();
        chk_out("cd_start", 59, 0, 1'b1, 1'b0);
        for (int i = 1; i <= 235; i++) begin
            drive(0, 0, (i == 10), 6'd10, 6'd10);
            tick();
            if (i == 10)
                chk_out("load_in_run", 57, 0, 1'b1, 1'b0);
        end
        drive(0, 0, 0, 6'd0, 6'd0);
        chk_out("cd_last", 1, 0, 1'b1, 1'b0);
        tick();
        chk_out("cd_done", 0, 0, 1'b0, 1'b1);
        drive(1, 0, 0, 6'd0, 6'd0);
        tick();
        chk_out("done_start", 0, 0, 1'b0, 1'b1);
        drive(0, 1, 0, 6'd0, 6'd0);
        tick();
        chk_out("cd_clear", 0, 0, 1'b0, 1'b0);
        drive(1, 0, 0, 6'd0, 6'd0);
        tick();
        chk_out("start_zero", 0, 0, 1'b0, 1'b0);
        drive(0, 0, 0, 6'd0, 6'd0);
        repeat (5) tick();
        chk_out("stay_idle", 0, 0, 1'b0, 1'b0);
`else
        for (int i = 0; i < 10; i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                drive((r == 0) ? tbl[i].start : 1'b0,
                      (r == 0) ? tbl[i].clear : 1'b0, 0, 6'd0, 6'd0);
                tick();
                chk_out($sformatf("vec%0d.%0d", i, r), tbl[i].sec, tbl[i].min,
                        tbl[i].run, tbl[i].alm);
            end
        end
        drive(0, 0, 0, 6'd0, 6'd0);

        repeat (3) tick();
        chk_out("pre_clear", 3, 0, 1'b1, 1'b0);
        drive(1, 1, 0, 6'd0, 6'd0);
        tick();
        chk_out("clr_prio", 0, 0, 1'b0, 1'b0);
        drive(0, 0, 0, 6'd0, 6'd0);
        repeat (4) tick();
        chk_out("clr_idle", 0, 0, 1'b0, 1'b0);

        drive(1, 0, 0, 6'd0, 6'd0);
        tick();
        drive(0, 0, 0, 6'd0, 6'd0);
        chk_out("long_start", 0, 0, 1'b1, 1'b0);
        repeat (239) tick();
        chk_out("pre_carry", 59, 0, 1'b1, 1'b0);
        tick();
        chk_out("carry", 0, 1, 1'b1, 1'b0);
        repeat (14155) tick();
        chk_out("pre_sat", 58, 59, 1'b1, 1'b0);
        tick();
        chk_out("sat", 59, 59, 1'b0, 1'b1);
        drive(1, 0, 0, 6'd0, 6'd0);
        tick();
        drive(0, 0, 0, 6'd0, 6'd0);
        chk_out("done_start", 59, 59, 1'b0, 1'b1);
        repeat (8) tick();
        chk_out("done_hold", 59, 59, 1'b0, 1'b1);
        drive(0, 1, 0, 6'd0, 6'd0);
        tick();
        drive(0, 0, 0, 6'd0, 6'd0);
        chk_out("done_clear", 0, 0, 1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
